// File: rtl/seq_shift_unit.sv
// Iterative shifter: one bit position per clock, valid/ready on both sides.
// Define SEQ_SHIFT_ROT_EN to make mode 11 rotate right; otherwise mode 11 passes data through.
module seq_shift_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shift,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] step;
   logic             skip_shift;

   // Single-bit step applied to the result register each SHIFT cycle.
   always_comb begin
      step = data_q;
      unique case (mode_q)
         2'b00: step = {data_q[WIDTH-2:0], 1'b0};
         2'b01: step = {1'b0, data_q[WIDTH-1:1]};
         2'b10: step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SEQ_SHIFT_ROT_EN
         2'b11: step = {data_q[0], data_q[WIDTH-1:1]};
`else
         2'b11: step = data_q;
`endif
         default: step = data_q;
      endcase
   end

`ifdef SEQ_SHIFT_ROT_EN
   assign skip_shift = (shift == '0);
`else
   assign skip_shift = (shift == '0) || (mode == 2'b11);
`endif

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               data_d  = data_in;
               mode_d  = mode;
               cnt_d   = shift;
               state_d = skip_shift ? StDone : StShift;
            end
         end
         StShift: begin
            data_d = step;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign data_out  = data_q;

endmodule
